// File: rtl/ddr_cfg_pkg.sv
// Shared types and constants for the DDR configuration register file.
// Reset values are stored at the maximum supported size; instances take the slice they need.
package ddr_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } cfg_state_t;

  localparam int CFG_MAX_REGS = 64;
  localparam int CFG_MAX_W    = 64;

  typedef logic [CFG_MAX_REGS-1:0][CFG_MAX_W-1:0] cfg_reset_arr_t;

  function automatic cfg_reset_arr_t gen_cfg_reset_vals();
    cfg_reset_arr_t v;
    for (int i = 0; i < CFG_MAX_REGS; i++) begin
      v[i] = 64'hA5C3_0F00_1234_0000 + 64'(i) * 64'h0001_0001_0101_0011;
    end
    return v;
  endfunction

  localparam cfg_reset_arr_t CFG_RESET_VALS = gen_cfg_reset_vals();

endpackage

// File: rtl/ddr_cfg_commit_fsm.sv
// Commit sequencer: waits for the DDR controller to go idle, then applies the shadow bank.
// state    | meaning
// IDLE     | shadow writable, no commit in flight
// PENDING  | commit requested, waiting for ctrl_idle
// APPLY    | active bank loads shadow bank at the end of this cycle
module ddr_cfg_commit_fsm
  import ddr_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       commit_req,
  input  logic       ctrl_idle,
  output cfg_state_t state,
  output logic       commit_ack
);

  cfg_state_t state_q, state_d;
  logic       ack_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      commit_ack <= 1'b0;
    end else begin
      state_q    <= state_d;
      commit_ack <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE:    if (commit_req) state_d = PENDING;
      PENDING: if (ctrl_idle) state_d = APPLY;
      APPLY: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ddr_config_regfile.sv
// Double-banked DDR configuration registers: shadow writes, atomic commit to the active bank.
// Optional DDR_CFG_PARITY_EN adds per-register even parity and a sticky parity_err output.
module ddr_config_regfile
  import ddr_cfg_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  parameter  int DATA_W   = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       commit_req,
  input  logic                       ctrl_idle,
  output logic                       commit_busy,
  output logic                       commit_ack,
  output logic [NUM_REGS*DATA_W-1:0] active_cfg,
  output logic                       err
`ifdef DDR_CFG_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  // One extra bit so the range check stays meaningful when NUM_REGS is a power of two.
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  cfg_state_t        state;
  logic              wr_in_range, rd_in_range, wr_ok;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] rd_mux;

  ddr_cfg_commit_fsm u_commit_fsm (
    .clk        (clk),
    .rst        (rst),
    .commit_req (commit_req),
    .ctrl_idle  (ctrl_idle),
    .state      (state),
    .commit_ack (commit_ack)
  );

  assign commit_busy = (state != IDLE);
  assign wr_in_range = ({1'b0, wr_addr} < REG_LIMIT);
  assign rd_in_range = ({1'b0, rd_addr} < REG_LIMIT);
  assign wr_ok       = wr_en && wr_in_range && !commit_busy;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_mux = shadow_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= CFG_RESET_VALS[i][DATA_W-1:0];
        active_q[i] <= CFG_RESET_VALS[i][DATA_W-1:0];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_addr == ADDR_W'(i)) shadow_q[i] <= wr_data;
        if (state == APPLY) active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? rd_mux : '0;
      err <= (wr_en && (!wr_in_range || commit_busy)) || (rd_en && !rd_in_range);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign active_cfg[g*DATA_W +: DATA_W] = active_q[g];
  end

`ifdef DDR_CFG_PARITY_EN
  logic [NUM_REGS-1:0] shadow_par, active_par, par_bad;

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      par_bad[i] = (^active_q[i]) ^ active_par[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_par[i] <= ^CFG_RESET_VALS[i][DATA_W-1:0];
        active_par[i] <= ^CFG_RESET_VALS[i][DATA_W-1:0];
      end
      parity_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_addr == ADDR_W'(i)) shadow_par[i] <= ^wr_data;
      end
      if (state == APPLY) active_par <= shadow_par;
      parity_err <= parity_err || (|par_bad);
    end
  end
`endif

endmodule

// File: doc/ddr_config_regfile.md
DDR_CONFIG_REGFILE -- requirements
Module: ddr_config_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, the number of configuration registers (2..64).
REQ-002 SHALL have parameter DATA_W, default 32, the register width in bits (8..64).
REQ-003 SHALL have localparam ADDR_W = $clog2(NUM_REGS), the address width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 wr_en  input  1  shadow write strobe.
REQ-007 wr_addr  input  ADDR_W  shadow write index.
REQ-008 wr_data  input  DATA_W  shadow write data.
REQ-009 rd_en  input  1  shadow read strobe.
REQ-010 rd_addr  input  ADDR_W  shadow read index.
REQ-011 rd_data  output  DATA_W  read data, registered.
REQ-012 rd_valid  output  1  rd_data qualifier, 1-cycle pulse.
REQ-013 commit_req  input  1  request to copy the shadow bank to the active bank.
REQ-014 ctrl_idle  input  1  DDR controller idle; a commit may apply only while high.
REQ-015 commit_busy  output  1  high in PENDING or APPLY.
REQ-016 commit_ack  output  1  1-cycle pulse, coincident with the first cycle of new active_cfg.
REQ-017 active_cfg  output  NUM_REGS*DATA_W  active bank, flattened, register 0 in the LSBs.
REQ-018 err  output  1  1-cycle pulse on a rejected access.

Function
REQ-019 The block SHALL hold shadow and active banks of NUM_REGS x DATA_W bits.
REQ-020 In IDLE, wr_en with wr_addr < NUM_REGS SHALL write shadow[wr_addr] at the next edge.
REQ-021 wr_en with wr_addr >= NUM_REGS, or any wr_en while commit_busy, SHALL be dropped and SHALL pulse err the next cycle.
REQ-022 Read latency SHALL be 1 cycle: rd_data = shadow[rd_addr] and rd_valid = 1 in the cycle after rd_en.
REQ-023 A read of an out-of-range address SHALL return 0, assert rd_valid and pulse err.
REQ-024 A same-cycle read and write of one address SHALL return the pre-write value.
REQ-025 When rd_en is low, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-026 The FSM states SHALL be IDLE, PENDING and APPLY.
REQ-027 IDLE->PENDING on commit_req; PENDING->APPLY when ctrl_idle=1; APPLY->IDLE unconditionally.
REQ-028 PENDING SHALL persist indefinitely while ctrl_idle=0.
REQ-029 In APPLY the active bank SHALL load the whole shadow bank atomically at one edge; commit_ack SHALL pulse in the following cycle.
REQ-030 Minimum commit latency: commit_req at cycle N, ctrl_idle high -> commit_ack and new active_cfg at N+3.
REQ-031 commit_req while commit_busy SHALL be ignored without err.
REQ-032 Simultaneous wr_en and commit_req in IDLE: the write SHALL complete, then the commit SHALL start, so the write is included.

Reset
REQ-033 rst SHALL immediately force IDLE, clear rd_data, rd_valid, commit_ack and err, and load both banks from CFG_RESET_VALS.
REQ-034 rst during PENDING or APPLY SHALL abort the commit with no partial update and no commit_ack.

Configuration
REQ-035 Macro DDR_CFG_PARITY_EN SHALL add one even-parity bit per shadow and active register, computed on write and copied on commit.
REQ-036 With DDR_CFG_PARITY_EN, an output parity_err (1 bit) SHALL assert when any active register fails its parity check, and SHALL be sticky until rst.
REQ-037 Without DDR_CFG_PARITY_EN, no parity storage SHALL exist and the parity_err port SHALL be absent.

Structure
REQ-038 Package ddr_cfg_pkg SHALL hold the FSM state enum (cfg_state_t) and the CFG_RESET_VALS constant array.
REQ-039 The commit FSM SHALL be a sub-module, ddr_cfg_commit_fsm, with ports for commit_req, ctrl_idle, state and commit_ack.

Verification
REQ-040 Write 0xDEADBEEF to addr 3, then read addr 3 -> rd_data=0xDEADBEEF with rd_valid one cycle after rd_en; active_cfg unchanged.
REQ-041 commit_req with ctrl_idle=1 -> commit_ack at N+3 and active_cfg register 3 = 0xDEADBEEF.
REQ-042 commit_req with ctrl_idle=0 for 20 cycles -> commit_busy high throughout, writes pulse err and shadow is unchanged; ctrl_idle rises -> ack 2 cycles later.
REQ-043 With NUM_REGS=8, write addr 9 (ADDR_W widened for the test) -> err pulse, no state change; read addr 9 -> rd_data=0.
REQ-044 rst asserted in PENDING -> IDLE immediately, both banks equal CFG_RESET_VALS, no commit_ack.
REQ-045 DDR_CFG_PARITY_EN: force-flip one active bit -> parity_err=1 and stays 1 until rst.
